// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: it grants one requester, drives the
// ALU from registered operands, and holds the captured result until the winner takes it.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned OPC_W  = 6,
  parameter int unsigned FAIR   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_A,
  input  logic [DATA_W-1:0] r0_B,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [OPC_W-1:0]  r0_opcode,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_A,
  input  logic [DATA_W-1:0] r1_B,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [OPC_W-1:0]  r1_opcode,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [OP_W-1:0]   alu_op,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_sign,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;
  logic   gnt_q;   // port currently owning the ALU
  logic   last_q;  // most recent grant, drives round-robin
  logic   grant;
  logic   accept;

  always_comb begin
    if (r0_valid && r1_valid) begin
      grant = (FAIR != 0) ? ~last_q : 1'b0;
    end else begin
      grant = r1_valid;
    end
    accept   = (state_q == StIdle) && (r0_valid || r1_valid);
    r0_ready = accept && !grant;
    r1_ready = accept && grant;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (gnt_q ? r1_rsp_ready : r0_rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_op       <= '0;
      alu_opcode   <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_sign     <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q      <= grant;
        last_q     <= grant;
        alu_A      <= grant ? r1_A : r0_A;
        alu_B      <= grant ? r1_B : r0_B;
        alu_op     <= grant ? r1_op : r0_op;
        alu_opcode <= grant ? r1_opcode : r0_opcode;
      end
      if (state_q == StIssue) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_sign     <= alu_sign;
        r0_rsp_valid <= !gnt_q;
        r1_rsp_valid <= gnt_q;
      end
      if (state_q == StResp && state_d == StIdle) begin
        r0_rsp_valid <= 1'b0;
        r1_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the EX-stage datapath, port 1 is an auxiliary unit such as the branch-compare or address helper.
- Arbitrates, latches the winner's operands, and drives the ALU from registers.
- Captures result/zero/sign one cycle later and holds them until the winner accepts the response.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged and still applies its BNE zero inversion internally.

Parameters:
DATA_W, 32, operand/result width
OP_W, 4, ALU operation code width
OPC_W, 6, instruction opcode width forwarded to the ALU
FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
rK_valid  in  1  request from port K (K=0,1); must stay high with stable operands until rK_ready
rK_ready  out  1  request from port K accepted this cycle
rK_A, rK_B  in  DATA_W  operands from port K
rK_op  in  OP_W  ALU operation from port K
rK_opcode  in  OPC_W  instruction opcode from port K
rK_rsp_valid  out  1  response for port K is held on rsp_*
rK_rsp_ready  in  1  port K consumes the response
rsp_result  out  DATA_W  captured ALU result
rsp_zero  out  1  captured ALU zero flag
rsp_sign  out  1  captured ALU sign flag
alu_A, alu_B  out  DATA_W  to ALU reg_A/reg_B
alu_op  out  OP_W  to ALU alu_op
alu_opcode  out  OPC_W  to ALU opcode_E
alu_result  in  DATA_W  from ALU
alu_zero, alu_sign  in  1  from ALU
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all registered outputs are 0: alu_*, rsp_*, rK_rsp_valid.
  - last_grant=1, so port 0 wins first.
  - Reset mid-operation discards the in-flight operation and its response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = port 0 if only r0_valid; port 1 if only r1_valid.
  - If both are valid: port 0 when FAIR=0, otherwise the port opposite last_grant.
  - rK_ready = (state==IDLE) && any valid && grant==K, combinational, one cycle.
  - On that edge: latch rK_A/B/op/opcode into alu_* registers, record the granted id, set last_grant=K, go to ISSUE.
  - With no valid request, stay in IDLE and hold alu_* at their previous values.
- ISSUE:
  - The ALU settles combinationally on the registered alu_* values.
  - At the edge, capture alu_result/alu_zero/alu_sign into rsp_*, set rK_rsp_valid for the granted K, go to RESP.
- RESP:
  - rK_rsp_valid and rsp_* are held stable.
  - When rK_rsp_ready is high (granted K only), clear rK_rsp_valid at the edge and go to IDLE.
  - rsp_ready from the non-granted port is ignored.
- Latency: request accepted at edge N, response visible after edge N+1, earliest return to IDLE at edge N+2. Peak throughput is one operation per 3 cycles.
- No request is accepted while busy; rK_ready stays 0 in ISSUE and RESP.
- A request raised in the same cycle as rsp_ready is arbitrated in the following IDLE cycle.
- Arithmetic: none inside this block; opcode is passed through unchanged, so the BNE zero inversion comes from the ALU.
- rsp_zero/rsp_sign reflect the ALU outputs exactly as sampled in ISSUE.
- At most one rK_rsp_valid is high at any time; rK_ready and rK_rsp_valid are never both high.
- Requester protocol violations (dropping valid before ready) have no effect, because arbitration is only evaluated in IDLE.

Test Plan:
- Reset then r0 request A=5, B=3, op=ADD. Required: r0_ready pulses 1 cycle, alu_A=5 next cycle, r0_rsp_valid with rsp_result=8, zero=0, sign=0 two edges after accept; held until r0_rsp_ready.
- Both ports valid continuously, FAIR=1, rsp_ready tied high. Required: grants alternate 0,1,0,1 with the first grant to port 0; each operation takes 3 cycles.
- Both ports valid, FAIR=0. Required: port 0 is granted every time; port 1 is granted only after r0_valid drops.
- r1 request opcode=6'h5 (BNE), A=7, B=7, op=SUB. Required: rsp_result=0 and rsp_zero=0 (inverted by the ALU); r1_rsp_valid only, and r0_rsp_ready pulses are ignored.
- Responses: op=SLT with A=0xFFFFFFFF, B=1 gives result=1; op=SUB with A=0, B=1 gives result=0xFFFFFFFF, sign=1. Hold rsp_ready low 4 cycles: rsp_* stay stable and busy stays 1.
- Assert reset during ISSUE. Required: state returns to IDLE immediately, rsp_valid=0, busy=0; the next simultaneous request goes to port 0.
